modbus_uart_frame_player: RTL and testbench

- Synthesizable, parametrised scripted UART-receiver model for the Modbus front end.
- Replays a loadable script of characters and inter-frame silences on the same handshake that a real UART RX presents to ModbusToWishbone (dataReceived/receiveReq/dataOut/silence/parityError/overflow).
- Adds runtime-loaded script memory, configurable gaps, looping, per-entry parity-error injection, and overflow on consumer timeout.
- Used in benches and as an on-chip self-test source.

---
 rtl/modbus_uart_frame_player.sv | 192 +++++++++++++++++++
 tb/tb_modbus_uart_frame_player.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_uart_frame_player.sv
// Scripted UART-receiver model: replays loaded characters and line silences on the
// dataReceived/receiveReq handshake, with parity-error injection, looping and consumer timeout.
`default_nettype none

module modbus_uart_frame_player #(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 16,
  parameter int ADDR_WIDTH     = 4,
  parameter int GAP_CYCLES     = 5,
  parameter int SILENCE_CYCLES = 5,
  parameter int RESP_TIMEOUT   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  loadWe,
  input  logic [ADDR_WIDTH-1:0] loadAddr,
  input  logic [DATA_WIDTH+3:0] loadData,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  loopEn,
  output logic                  busy,
  output logic                  done,
  output logic                  dataReceived,
  input  logic                  receiveReq,
  output logic [DATA_WIDTH:0]   dataOut,
  output logic                  silence,
  output logic                  parityError,
  output logic                  overflow
);

  localparam int CNT_MAX = (GAP_CYCLES > SILENCE_CYCLES) ? GAP_CYCLES : SILENCE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int WW      = (RESP_TIMEOUT > 1) ? $clog2(RESP_TIMEOUT) : 1;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX  = ADDR_WIDTH'(DEPTH - 1);
  localparam logic [CW-1:0]         GAP_LOAD  = CW'(GAP_CYCLES);
  localparam logic [CW-1:0]         SIL_LOAD  = CW'(SILENCE_CYCLES);
  localparam logic [WW-1:0]         WAIT_LAST = WW'(RESP_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_DECODE  = 3'd1,
    S_GAP     = 3'd2,
    S_PRESENT = 3'd3,
    S_SILENCE = 3'd4,
    S_DONE    = 3'd5
  } state_t;

  logic [DATA_WIDTH+3:0] mem [DEPTH];

  state_t                state, state_n;
  logic [ADDR_WIDTH-1:0] index, index_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [WW-1:0]         wcnt, wcnt_n;
  logic                  busy_n, done_n, dr_n, sil_n, pe_n, ovf_n;
  logic [DATA_WIDTH:0]   dout_n;

  logic [DATA_WIDTH+3:0] entry;
  logic                  e_bit, s_bit, p_bit;
  state_t                adv_state;
  logic [ADDR_WIDTH-1:0] adv_index;

  always_ff @(posedge clk) begin
    if (loadWe && !busy) mem[loadAddr] <= loadData;
  end

  assign entry = mem[index];
  assign e_bit = entry[DATA_WIDTH+3];
  assign s_bit = entry[DATA_WIDTH+2];
  assign p_bit = entry[DATA_WIDTH+1];

  // Where playback goes after a finished character or silence.
  assign adv_index = (index == LAST_IDX) ? '0 : index + ADDR_WIDTH'(1);
  assign adv_state = ((index != LAST_IDX) || loopEn) ? S_DECODE : S_DONE;

  always_comb begin
    state_n = state;
    index_n = index;
    cnt_n   = cnt;
    wcnt_n  = wcnt;
    busy_n  = busy;
    dr_n    = dataReceived;
    dout_n  = dataOut;
    sil_n   = silence;
    pe_n    = parityError;
    ovf_n   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          index_n = '0;
          busy_n  = 1'b1;
          state_n = S_DECODE;
        end
      end
      S_DECODE: begin
        if (e_bit) begin
          if (loopEn) index_n = '0;
          else        state_n = S_DONE;
        end else if (s_bit) begin
          sil_n   = 1'b1;
          cnt_n   = SIL_LOAD;
          state_n = S_SILENCE;
        end else begin
          cnt_n   = GAP_LOAD;
          state_n = S_GAP;
        end
      end
      S_GAP: begin
        if (cnt == CW'(1)) begin
          dr_n    = 1'b1;
          dout_n  = entry[DATA_WIDTH:0];
          pe_n    = p_bit;
          wcnt_n  = '0;
          state_n = S_PRESENT;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_PRESENT: begin
        // Acknowledge is checked first so it wins over a coincident timeout.
        if (receiveReq) begin
          dr_n    = 1'b0;
          pe_n    = 1'b0;
          index_n = adv_index;
          state_n = adv_state;
        end else if ((RESP_TIMEOUT != 0) && (wcnt == WAIT_LAST)) begin
          ovf_n   = 1'b1;
          dr_n    = 1'b0;
          pe_n    = 1'b0;
          index_n = adv_index;
          state_n = adv_state;
        end else begin
          wcnt_n = wcnt + WW'(1);
        end
      end
      S_SILENCE: begin
        if (cnt == CW'(1)) begin
          sil_n   = 1'b0;
          index_n = adv_index;
          state_n = adv_state;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      S_DONE: begin
        busy_n  = 1'b0;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
    if (abort && (state != S_IDLE)) begin
      state_n = S_IDLE;
      busy_n  = 1'b0;
      dr_n    = 1'b0;
      sil_n   = 1'b0;
      pe_n    = 1'b0;
      ovf_n   = 1'b0;
    end
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      index        <= '0;
      cnt          <= '0;
      wcnt         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      dataReceived <= 1'b0;
      dataOut      <= '0;
      silence      <= 1'b0;
      parityError  <= 1'b0;
      overflow     <= 1'b0;
    end else begin
      state        <= state_n;
      index        <= index_n;
      cnt          <= cnt_n;
      wcnt         <= wcnt_n;
      busy         <= busy_n;
      done         <= done_n;
      dataReceived <= dr_n;
      dataOut      <= dout_n;
      silence      <= sil_n;
      parityError  <= pe_n;
      overflow     <= ovf_n;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_modbus_uart_frame_player.sv
// Scoreboard bench for modbus_uart_frame_player: expected characters are queued as scripts
// are loaded and compared against characters captured from the handshake.
`default_nettype none

module tb_modbus_uart_frame_player;

  logic        clk = 1'b0, rst = 1'b0, loadWe = 1'b0, start = 1'b0, abort = 1'b0;
  logic        loopEn = 1'b0, receiveReq = 1'b0;
  logic [3:0]  loadAddr = '0;
  logic [11:0] loadData = '0;
  logic        busy, done, dataReceived, silence, parityError, overflow;
  logic [8:0]  dataOut;

  modbus_uart_frame_player #(
    .DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4),
    .GAP_CYCLES(5), .SILENCE_CYCLES(5), .RESP_TIMEOUT(16)
  ) dut (
    .clk(clk), .rst(rst), .loadWe(loadWe), .loadAddr(loadAddr), .loadData(loadData),
    .start(start), .abort(abort), .loopEn(loopEn), .busy(busy), .done(done),
    .dataReceived(dataReceived), .receiveReq(receiveReq), .dataOut(dataOut),
    .silence(silence), .parityError(parityError), .overflow(overflow)
  );

  int checks = 0, passed = 0;
  int edges = 0, start_edge = 0, ack_mode = 0;
  int hi_run = 0, sil_run = 0, ovf_cnt = 0, done_cnt = 0, overlap = 0;
  logic prev_dr = 1'b0, prev_sil = 1'b0;
  logic [9:0] exp_q[$], got_q[$];
  int got_edge_q[$], hi_q[$], sil_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) edges++;

  // Monitor and consumer: captures {parityError,dataOut} at each new character and drives receiveReq.
  always @(negedge clk) begin
    if (dataReceived && !prev_dr) begin
      got_q.push_back({parityError, dataOut});
      got_edge_q.push_back(edges);
    end
    if (dataReceived) hi_run++;
    else if (prev_dr) begin hi_q.push_back(hi_run); hi_run = 0; end
    if (silence) sil_run++;
    else if (prev_sil) begin sil_q.push_back(sil_run); sil_run = 0; end
    if (dataReceived && silence) overlap++;
    if (overflow) ovf_cnt++;
    if (done) done_cnt++;
    case (ack_mode)
      1:       receiveReq = dataReceived;
      2:       receiveReq = dataReceived && (hi_run == 16);
      default: receiveReq = 1'b0;
    endcase
    prev_dr  = dataReceived;
    prev_sil = silence;
  end

  function automatic logic [11:0] ent(bit e, bit s, bit p, bit n, logic [7:0] d);
    return {e, s, p, n, d};
  endfunction

  task automatic load_entry(input int addr, input logic [11:0] d);
    @(negedge clk);
    loadWe = 1'b1; loadAddr = 4'(addr); loadData = d;
    @(negedge clk);
    loadWe = 1'b0;
  endtask

  task automatic clear_sb();
    exp_q.delete(); got_q.delete(); got_edge_q.delete(); hi_q.delete(); sil_q.delete();
    ovf_cnt = 0; done_cnt = 0; overlap = 0;
  endtask

  task automatic do_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    start_edge = edges;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++;
    if ({busy, done, dataReceived, silence, parityError, overflow} !== 6'b0)
      $display("FAIL reset_flags: got %b expected 000000", {busy, done, dataReceived, silence, parityError, overflow});
    else passed++;
    checks++;
    if (dataOut !== 9'h000) $display("FAIL reset_dataOut: got %h expected 000", dataOut);
    else passed++;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_normal();
    logic [7:0] d [8] = '{8'h37, 8'h01, 8'h00, 8'h00, 8'hA5, 8'hFF, 8'h02, 8'h8C};
    logic [9:0] e, g;
    bit ok;
    clear_sb();
    for (int i = 0; i < 8; i++) begin
      load_entry(i, ent(0, 0, 0, 0, d[i]));
      exp_q.push_back({2'b00, d[i]});
    end
    load_entry(8, ent(1, 0, 0, 0, 8'h00));
    ack_mode = 1; loopEn = 1'b0;
    do_start();
    wait_idle(1000, ok);
    checks++;
    if (!ok) $display("FAIL normal_finish: busy got 1 expected 0 within budget"); else passed++;
    checks++;
    if (got_q.size() != 8) $display("FAIL normal_count: got %0d expected 8", got_q.size()); else passed++;
    if (got_edge_q.size() > 0) begin
      checks++;
      if (got_edge_q[0] - start_edge != 6)
        $display("FAIL normal_latency: got %0d expected 6", got_edge_q[0] - start_edge);
      else passed++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== e) $display("FAIL normal_char: got %h expected %h", g, e); else passed++;
    end
    checks++;
    if (done_cnt != 1) $display("FAIL normal_done: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_silence();
    logic [9:0] e, g;
    bit ok;
    clear_sb();
    load_entry(0, ent(0, 0, 0, 0, 8'h11));
    load_entry(1, ent(0, 1, 0, 0, 8'h00));
    load_entry(2, ent(0, 0, 0, 0, 8'h22));
    load_entry(3, ent(1, 0, 0, 0, 8'h00));
    exp_q.push_back(10'h011); exp_q.push_back(10'h022);
    ack_mode = 1;
    do_start();
    wait_idle(1000, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== e) $display("FAIL silence_char: got %h expected %h", g, e); else passed++;
    end
    checks++;
    if (sil_q.size() != 1 || sil_q[0] != 5)
      $display("FAIL silence_len: got %0d runs first %0d expected 1 run of 5", sil_q.size(), (sil_q.size() > 0) ? sil_q[0] : -1);
    else passed++;
    checks++;
    if (overlap != 0) $display("FAIL silence_overlap: got %0d expected 0", overlap); else passed++;
  endtask

  task automatic test_errors(input int mode);
    logic [9:0] e, g;
    bit ok;
    clear_sb();
    load_entry(0, ent(0, 0, 1, 1, 8'h55));
    load_entry(1, ent(0, 0, 0, 0, 8'h66));
    load_entry(2, ent(1, 0, 0, 0, 8'h00));
    exp_q.push_back(10'h355); exp_q.push_back(10'h066);
    ack_mode = mode;
    do_start();
    wait_idle(1000, ok);
    ack_mode = 1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== e) $display("FAIL err_char mode%0d: got %h expected %h", mode, g, e); else passed++;
    end
    checks++;
    if (hi_q.size() != 2) $display("FAIL err_valid_runs mode%0d: got %0d expected 2", mode, hi_q.size());
    else passed++;
    foreach (hi_q[i]) begin
      checks++;
      if (hi_q[i] != 16) $display("FAIL err_valid_len mode%0d: got %0d expected 16", mode, hi_q[i]);
      else passed++;
    end
    checks++;
    if (ovf_cnt != ((mode == 0) ? 2 : 0))
      $display("FAIL err_overflow mode%0d: got %0d expected %0d", mode, ovf_cnt, (mode == 0) ? 2 : 0);
    else passed++;
    checks++;
    if (done_cnt != 1) $display("FAIL err_done mode%0d: got %0d expected 1", mode, done_cnt); else passed++;
  endtask

  task automatic test_loop();
    logic [9:0] e, g;
    bit ok;
    clear_sb();
    load_entry(0, ent(0, 0, 0, 0, 8'h0A));
    load_entry(1, ent(0, 0, 0, 1, 8'h0B));
    load_entry(2, ent(0, 0, 0, 0, 8'h0C));
    load_entry(3, ent(1, 0, 0, 0, 8'h00));
    for (int r = 0; r < 3; r++) begin
      exp_q.push_back(10'h00A); exp_q.push_back(10'h10B); exp_q.push_back(10'h00C);
    end
    ack_mode = 1; loopEn = 1'b1;
    do_start();
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (got_q.size() >= 9) begin ok = 1'b1; break; end
    end
    abort = 1'b1;
    @(negedge clk); abort = 1'b0; loopEn = 1'b0;
    checks++;
    if (!ok) $display("FAIL loop_reps: got %0d chars expected 9", got_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== e) $display("FAIL loop_char: got %h expected %h", g, e); else passed++;
    end
    checks++;
    if (done_cnt != 0 || busy !== 1'b0)
      $display("FAIL loop_end: got done=%0d busy=%b expected done=0 busy=0", done_cnt, busy);
    else passed++;
  endtask

  task automatic test_wrap();
    logic [9:0] e, g;
    bit ok;
    clear_sb();
    for (int i = 0; i < 16; i++) begin
      load_entry(i, ent(0, 0, 0, i[0], 8'(8'h80 + i)));
      exp_q.push_back({1'b0, i[0], 8'(8'h80 + i)});
    end
    ack_mode = 1; loopEn = 1'b0;
    do_start();
    wait_idle(2000, ok);
    checks++;
    if (got_q.size() != 16) $display("FAIL wrap_count: got %0d expected 16", got_q.size()); else passed++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== e) $display("FAIL wrap_char: got %h expected %h", g, e); else passed++;
    end
    checks++;
    if (!ok || done_cnt != 1) $display("FAIL wrap_done: got %0d expected 1", done_cnt); else passed++;
  endtask

  task automatic test_abort();
    clear_sb();
    load_entry(0, ent(0, 0, 0, 0, 8'h11));
    load_entry(1, ent(1, 0, 0, 0, 8'h00));
    ack_mode = 1;
    do_start();
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    checks++;
    if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy); else passed++;
    repeat (15) @(negedge clk);
    checks++;
    if (got_q.size() != 0 || done_cnt != 0)
      $display("FAIL abort_quiet: got chars=%0d done=%0d expected 0 and 0", got_q.size(), done_cnt);
    else passed++;
  endtask

  task automatic test_load_busy();
    logic [9:0] e, g;
    bit ok;
    clear_sb();
    load_entry(0, ent(0, 0, 0, 0, 8'h41));
    load_entry(1, ent(0, 0, 0, 0, 8'h42));
    load_entry(2, ent(1, 0, 0, 0, 8'h00));
    ack_mode = 1;
    do_start();
    load_entry(0, ent(0, 0, 0, 0, 8'h99));
    load_entry(1, ent(1, 0, 0, 0, 8'h00));
    wait_idle(1000, ok);
    clear_sb();
    exp_q.push_back(10'h041); exp_q.push_back(10'h042);
    do_start();
    wait_idle(1000, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== e) $display("FAIL loadbusy_char: got %h expected %h", g, e); else passed++;
    end
  endtask

  task automatic test_async_reset();
    logic [9:0] e, g;
    bit ok;
    clear_sb();
    ack_mode = 0;
    do_start();
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dataReceived) begin ok = 1'b1; break; end
    end
    checks++;
    if (!ok) $display("FAIL areset_present: dataReceived got 0 expected 1"); else passed++;
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({dataReceived, busy, silence} !== 3'b000)
      $display("FAIL areset_drop: got %b expected 000", {dataReceived, busy, silence});
    else passed++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    clear_sb();
    ack_mode = 1;
    exp_q.push_back(10'h041); exp_q.push_back(10'h042);
    do_start();
    wait_idle(1000, ok);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      g = (got_q.size() > 0) ? got_q.pop_front() : 10'bx;
      checks++;
      if (g !== e) $display("FAIL areset_retained: got %h expected %h", g, e); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_silence();
    test_errors(0);
    test_errors(2);
    test_loop();
    test_wrap();
    test_abort();
    test_load_busy();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

`default_nettype wire
